// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment display blocks: dark pattern, hex glyph table and
// the brightness step shift.
package seg7_pkg;

   localparam logic [7:0] SEG_OFF = 8'hFF;

   // A slot is divided into 16 brightness steps
   localparam int unsigned BRIGHT_SHIFT = 4;

   // Active-low {G,F,E,D,C,B,A} glyphs, indexed by hex value (entry 0 is the rightmost field)
   localparam logic [15:0][6:0] SEG_TABLE = {
      7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h18, 7'h00,
      7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
   };

   function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
      return SEG_TABLE[hex];
   endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex-to-seven-segment decoder, active-low {G..A}.
module seg7_hex_decode
   import seg7_pkg::*;
(
   input  logic [3:0] hex_i,
   output logic [6:0] seg_n_o
);

   assign seg_n_o = hex_to_seg(hex_i);

endmodule

// File: rtl/seg7_scan_driver.sv
// N-digit multiplexed seven-segment driver with self-timed scan, frame-coherent input
// snapshot, per-digit blank/blink/dp and global brightness.
module seg7_scan_driver
   import seg7_pkg::*;
#(
   parameter int unsigned NUM_DIGITS   = 4,
   parameter int unsigned CLK_DIV      = 100000,
   parameter int unsigned BLINK_FRAMES = 64
) (
   input  logic                    src_clk,
   input  logic                    src_rst,
   input  logic [4*NUM_DIGITS-1:0] digit_vals,
   input  logic [NUM_DIGITS-1:0]   dp,
   input  logic [NUM_DIGITS-1:0]   blank,
   input  logic [NUM_DIGITS-1:0]   blink,
   input  logic [3:0]              brightness,
   output logic [NUM_DIGITS-1:0]   anode,
   output logic [7:0]              segment,
   output logic                    frame_tick
);

   localparam int unsigned SlotW = $clog2(CLK_DIV);
   localparam int unsigned DigW  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int unsigned FrW   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam int unsigned Step  = CLK_DIV >> BRIGHT_SHIFT;

   logic [SlotW-1:0]        slot_cnt_q, slot_cnt_d;
   logic [DigW-1:0]         dig_idx_q, dig_idx_d;
   logic [FrW-1:0]          frame_cnt_q, frame_cnt_d;
   logic                    blink_ph_q, blink_ph_d;
   logic [4*NUM_DIGITS-1:0] vals_q, vals_d;
   logic [NUM_DIGITS-1:0]   dp_q, dp_d, blank_q, blank_d, blink_q, blink_d;
   logic [3:0]              bright_q, bright_d;
   logic [NUM_DIGITS-1:0]   anode_q, anode_d;
   logic [7:0]              segment_q, segment_d;
   logic                    frame_tick_q, frame_tick_d;

   logic        slot_last, dig_last, frame_start, frame_end, lit;
   logic [3:0]  val_sel;
   logic [6:0]  seg_dec;
   logic [31:0] on_limit;

   always_comb begin
      slot_last   = (slot_cnt_q == SlotW'(CLK_DIV - 1));
      dig_last    = (dig_idx_q == DigW'(NUM_DIGITS - 1));
      frame_start = (slot_cnt_q == '0) && (dig_idx_q == '0);
      frame_end   = slot_last && dig_last;

      slot_cnt_d = slot_last ? '0 : slot_cnt_q + 1'b1;
      dig_idx_d  = dig_idx_q;
      if (slot_last) begin
         dig_idx_d = dig_last ? '0 : dig_idx_q + 1'b1;
      end

      frame_cnt_d = frame_cnt_q;
      blink_ph_d  = blink_ph_q;
      if (frame_end) begin
         if (frame_cnt_q == FrW'(BLINK_FRAMES - 1)) begin
            frame_cnt_d = '0;
            blink_ph_d  = ~blink_ph_q;
         end else begin
            frame_cnt_d = frame_cnt_q + 1'b1;
         end
      end

      vals_d   = frame_start ? digit_vals : vals_q;
      dp_d     = frame_start ? dp         : dp_q;
      blank_d  = frame_start ? blank      : blank_q;
      blink_d  = frame_start ? blink      : blink_q;
      bright_d = frame_start ? brightness : bright_q;
   end

   assign val_sel = vals_d[{dig_idx_q, 2'b00} +: 4];

   seg7_hex_decode u_hex_decode (
      .hex_i   (val_sel),
      .seg_n_o (seg_dec)
   );

   // Outputs lag the counters by one cycle, so the last count of a slot is what lands on
   // slot_cnt 0 and forms the dark gap between digits. Using the *_d snapshot lets the
   // first slot of a frame already show the freshly captured values.
   always_comb begin
      on_limit = (32'(bright_d) + 32'd1) * Step;
      lit      = !blank_d[dig_idx_q] && !(blink_d[dig_idx_q] && blink_ph_q)
                 && (32'(slot_cnt_q) < on_limit) && !slot_last;
      anode_d      = lit ? ~({{(NUM_DIGITS - 1){1'b0}}, 1'b1} << dig_idx_q) : '1;
      segment_d    = lit ? {~dp_d[dig_idx_q], seg_dec} : SEG_OFF;
      frame_tick_d = frame_start;
   end

   always_ff @(posedge src_clk or posedge src_rst) begin
      if (src_rst) begin
         slot_cnt_q   <= '0;
         dig_idx_q    <= '0;
         frame_cnt_q  <= '0;
         blink_ph_q   <= 1'b0;
         vals_q       <= '0;
         dp_q         <= '0;
         blank_q      <= '0;
         blink_q      <= '0;
         bright_q     <= '0;
         anode_q      <= '1;
         segment_q    <= SEG_OFF;
         frame_tick_q <= 1'b0;
      end else begin
         slot_cnt_q   <= slot_cnt_d;
         dig_idx_q    <= dig_idx_d;
         frame_cnt_q  <= frame_cnt_d;
         blink_ph_q   <= blink_ph_d;
         vals_q       <= vals_d;
         dp_q         <= dp_d;
         blank_q      <= blank_d;
         blink_q      <= blink_d;
         bright_q     <= bright_d;
         anode_q      <= anode_d;
         segment_q    <= segment_d;
         frame_tick_q <= frame_tick_d;
      end
   end

   assign anode      = anode_q;
   assign segment    = segment_q;
   assign frame_tick = frame_tick_q;

endmodule
